register_file_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_read_port.sv | 48 ++++
 rtl/register_file_sb.sv | 114 +++++++++++
 tb/tb_register_file_sb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the pipelined core's integer register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_pkg;

    // Default geometry of the RV32I integer register file.
    localparam int          DEF_XLEN    = 32;
    localparam int          DEF_NREG    = 32;
    localparam int          DEF_SP_IDX  = 2;
    localparam logic [31:0] DEF_SP_INIT = 32'h0000_0200;

    // ABI register indices.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One combinational read port of the register file with write-first bypass.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; busy tells decode whether the operand is still in flight.
//
// Ports:
//   addr              register index read by this port
//   regs              view of the whole storage array, register i at regs[i]
//   busy_vec          scoreboard busy bits, bit 0 always 0
//   wr_en/wr_addr/wr_data  this cycle's writeback, used for the bypass
//   data              operand value (0 for x0)
//   busy              operand not yet available
module rf_read_port
    import rf_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int NREG = DEF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy_vec,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            data,
    output logic                       busy
);

    logic wr_hit;

    // A writeback to the register being read this cycle supplies its value
    // directly, so the consumer never sees the stale stored copy.
    assign wr_hit = wr_en && (wr_addr == addr);

    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end else if (wr_hit) begin
            data = wr_data;
        end
    end

    // A bypassed value is ready now, so the port is not busy even though the
    // busy bit only clears at the coming edge.
    assign busy = busy_vec[addr] && !wr_hit;

endmodule : rf_read_port

// File: rtl/register_file_sb.sv
// Integer register file with NRP read ports, one write port and busy-bit scoreboard.
// Latency: reads 0 cycles; writes, busy bits and busy_cnt update at the next edge.
// Backpressure: stall goes high while any read port names a busy register.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   rs_addr/rs_data    NRP read ports, port p at [p*AW +: AW] / [p*XLEN +: XLEN]
//   rs_busy            per-port busy flag after writeback bypass
//   wr_en/wr_addr/wr_data  writeback: commit value and release reservation
//   alloc_en/alloc_addr    issue: reserve destination register
//   stall              OR of rs_busy
//   busy_cnt           number of registers currently reserved
module register_file_sb
    import rf_pkg::*;
#(
    parameter  int              XLEN    = DEF_XLEN,
    parameter  int              NREG    = DEF_NREG,
    parameter  int              NRP     = 2,
    parameter  int              SP_IDX  = DEF_SP_IDX,
    parameter  logic [XLEN-1:0] SP_INIT = XLEN'(DEF_SP_INIT),
    localparam int              AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRP*AW-1:0]    rs_addr,
    output logic [NRP*XLEN-1:0]  rs_data,
    output logic [NRP-1:0]       rs_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 stall,
    output logic [AW:0]          busy_cnt
);

    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           busy;

    // x0 is a constant: no storage, never reserved.
    assign regs[0] = '0;
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        localparam logic [XLEN-1:0] RST_VAL = (i == SP_IDX) ? SP_INIT : '0;

        logic            wr_hit;
        logic            al_hit;
        logic [XLEN-1:0] q;
        logic            b;

        assign wr_hit = wr_en    && (wr_addr    == AW'(i));
        assign al_hit = alloc_en && (alloc_addr == AW'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= RST_VAL;
            end else if (wr_hit) begin
                q <= wr_data;
            end
        end

        // Allocation beats release: a new producer issued in the same cycle
        // the old one writes back still owns the register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b <= 1'b0;
            end else if (al_hit) begin
                b <= 1'b1;
            end else if (wr_hit) begin
                b <= 1'b0;
            end
        end

        assign regs[i] = q;
        assign busy[i] = b;
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        rf_read_port #(
            .XLEN (XLEN),
            .NREG (NREG)
        ) u_port (
            .addr     (rs_addr[p*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rs_data[p*XLEN +: XLEN]),
            .busy     (rs_busy[p])
        );
    end

    assign stall = |rs_busy;

    // With one alloc and one write per cycle at most one bit rises and at
    // most one falls, so the counter moves by -1, 0 or +1.
    logic rise;
    logic fall;

    assign rise = alloc_en && (alloc_addr != '0) && !busy[alloc_addr];
    assign fall = wr_en && (wr_addr != '0) && busy[wr_addr]
                  && !(alloc_en && (alloc_addr == wr_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + (AW+1)'(rise) - (AW+1)'(fall);
        end
    end

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: default instance plus NREG=16/NRP=3 instance.
// Latency: expectations are sampled in the same cycle the stimulus is applied.
// Backpressure: none; the monitor drains every queued expectation each cycle.
module tb_register_file_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults, 32 registers, 2 ports.
    logic [9:0]  a_rs_addr;
    logic [63:0] a_rs_data;
    logic [1:0]  a_rs_busy;
    logic        a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic        a_stall;
    logic [5:0]  a_busy_cnt;

    // Instance B: 16 registers, 3 ports, SP resets to 0x400.
    logic [11:0] b_rs_addr;
    logic [95:0] b_rs_data;
    logic [2:0]  b_rs_busy;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_alloc_en;
    logic [3:0]  b_alloc_addr;
    logic        b_stall;
    logic [4:0]  b_busy_cnt;

    register_file_sb #(.NRP(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr),
        .stall(a_stall), .busy_cnt(a_busy_cnt)
    );

    register_file_sb #(.NREG(16), .NRP(3), .SP_INIT(32'h0000_0400)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
        .stall(b_stall), .busy_cnt(b_busy_cnt)
    );

    // Reference model: architectural register contents and reservation set.
    logic [31:0] mem [2][32];
    bit          bsy [2][32];

    typedef struct {
        int               d;
        string            nm;
        logic [2:0][31:0] data;
        logic [2:0]       busy;
        logic             stall;
        int               cnt;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                mem[d][i] = '0;
                bsy[d][i] = 1'b0;
            end
        end
        mem[0][2] = 32'h0000_0200;
        mem[1][2] = 32'h0000_0400;
    endfunction

    function automatic void push_exp(input int d, input string nm, input int r0, input int r1,
                                     input int r2, input bit we, input int wa,
                                     input logic [31:0] wd);
        exp_t e;
        int   ra[3];
        int   np;
        bit   hit;
        ra[0] = r0; ra[1] = r1; ra[2] = r2;
        np = (d == 0) ? 2 : 3;
        e.d = d; e.nm = nm; e.data = '0; e.busy = '0; e.stall = 1'b0; e.cnt = 0;
        for (int p = 0; p < np; p++) begin
            hit = we && (wa == ra[p]);
            if (ra[p] == 0)  e.data[p] = '0;
            else if (hit)    e.data[p] = wd;
            else             e.data[p] = mem[d][ra[p]];
            e.busy[p] = bsy[d][ra[p]] && !hit;
            e.stall = e.stall | e.busy[p];
        end
        for (int i = 0; i < 32; i++) e.cnt += int'(bsy[d][i]);
        q.push_back(e);
    endfunction

    task automatic idle_all();
        a_wr_en = 1'b0; a_alloc_en = 1'b0;
        b_wr_en = 1'b0; b_alloc_en = 1'b0;
    endtask

    task automatic set_addr(input int d, input int r0, input int r1, input int r2);
        if (d == 0) a_rs_addr = {5'(r1), 5'(r0)};
        else        b_rs_addr = {4'(r2), 4'(r1), 4'(r0)};
    endtask

    task automatic cycle(input int d, input string nm, input bit we, input int wa,
                         input logic [31:0] wd, input bit ae, input int aa,
                         input int r0, input int r1, input int r2);
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle_all();
        set_addr(d, r0, r1, r2);
        if (d == 0) begin
            a_wr_en = we; a_wr_addr = 5'(wa); a_wr_data = wd;
            a_alloc_en = ae; a_alloc_addr = 5'(aa);
        end else begin
            b_wr_en = we; b_wr_addr = 4'(wa); b_wr_data = wd;
            b_alloc_en = ae; b_alloc_addr = 4'(aa);
        end
        push_exp(d, nm, r0, r1, r2, we, wa, wd);
        // Architectural effect of the coming edge: commit, then reserve.
        if (we && wa != 0) begin
            mem[d][wa] = wd;
            bsy[d][wa] = 1'b0;
        end
        if (ae && aa != 0) bsy[d][aa] = 1'b1;
    endtask

    task automatic do_reset(input int d, input string nm, input int r0, input int r1,
                            input int r2);
        @(negedge clk); #1;
        rst_n = 1'b0;
        idle_all();
        set_addr(d, r0, r1, r2);
        model_reset();
        push_exp(d, nm, r0, r1, r2, 1'b0, 0, '0);
    endtask

    task automatic rand_cycle(input int d);
        int hi, r0, r1, r2, wa, aa;
        bit we, ae;
        hi = (d == 0) ? 31 : 15;
        if ($urandom_range(0, 1) == 1) hi = 7;
        r0 = $urandom_range(0, hi); r1 = $urandom_range(0, hi); r2 = $urandom_range(0, hi);
        we = ($urandom_range(0, 1) == 1);
        ae = ($urandom_range(0, 2) != 0);
        wa = ($urandom_range(0, 2) == 0) ? r0 : $urandom_range(0, hi);
        aa = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, hi);
        cycle(d, "rnd", we, wa, 32'($urandom), ae, aa, r0, r1, r2);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: the outputs are combinational, so each cycle's expectation is
    // checked mid-cycle, after the driver has settled the inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.d == 0) begin
                    for (int p = 0; p < 2; p++)
                        chk($sformatf("%s.a.data%0d", e.nm, p), a_rs_data[p*32 +: 32], e.data[p]);
                    chk({e.nm, ".a.busy"},  a_rs_busy,  e.busy[1:0]);
                    chk({e.nm, ".a.stall"}, a_stall,    e.stall);
                    chk({e.nm, ".a.cnt"},   a_busy_cnt, e.cnt);
                end else begin
                    for (int p = 0; p < 3; p++)
                        chk($sformatf("%s.b.data%0d", e.nm, p), b_rs_data[p*32 +: 32], e.data[p]);
                    chk({e.nm, ".b.busy"},  b_rs_busy,  e.busy);
                    chk({e.nm, ".b.stall"}, b_stall,    e.stall);
                    chk({e.nm, ".b.cnt"},   b_busy_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        a_rs_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_alloc_en = 1'b0; a_alloc_addr = '0;
        b_rs_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_alloc_en = 1'b0; b_alloc_addr = '0;
        model_reset();

        do_reset(0, "reset", 2, 5, 0);
        // x0 can be neither written nor reserved.
        cycle(0, "x0_wr",   1, 0, 32'hDEAD, 1, 0, 0, 0, 0);
        cycle(0, "x0_rd",   0, 0, '0,       0, 0, 0, 0, 0);
        // Write-first bypass.
        cycle(0, "byp_init", 1, 5, 32'h11, 0, 0, 5, 0, 0);
        cycle(0, "byp",      1, 5, 32'h22, 0, 0, 5, 2, 0);
        cycle(0, "byp_after", 0, 0, '0,    0, 0, 5, 0, 0);
        // Reserve then release x7.
        cycle(0, "alloc7",  0, 0, '0,     1, 7, 0, 0, 0);
        cycle(0, "busy7",   0, 0, '0,     0, 0, 7, 0, 0);
        cycle(0, "wb7",     1, 7, 32'h33, 0, 0, 7, 0, 0);
        cycle(0, "free7",   0, 0, '0,     0, 0, 7, 0, 0);
        // Alloc and write of the same register in one cycle.
        cycle(0, "alloc9",  0, 0, '0,     1, 9, 0, 0, 0);
        cycle(0, "both9",   1, 9, 32'h44, 1, 9, 9, 0, 0);
        cycle(0, "after9",  0, 0, '0,     0, 0, 9, 5, 0);
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset(0, "rnd_rst", 2, 9, 0);
            else          rand_cycle(0);
        end

        // Second geometry.
        do_reset(1, "b_reset", 2, 0, 5);
        cycle(1, "b_w3", 1, 3, 32'hA3, 0, 0, 2, 0, 0);
        cycle(1, "b_w4", 1, 4, 32'hB4, 0, 0, 3, 2, 0);
        cycle(1, "b_w5", 1, 5, 32'hC5, 0, 0, 3, 4, 2);
        cycle(1, "b_rd", 0, 0, '0,     0, 0, 3, 4, 5);
        for (int i = 1; i < 16; i++) cycle(1, "b_fill", 0, 0, '0, 1, i, i, 2, 0);
        cycle(1, "b_full",  0, 0, '0, 0, 0, 1, 15, 0);
        cycle(1, "b_again", 0, 0, '0, 1, 6, 6, 0, 0);
        cycle(1, "b_still", 0, 0, '0, 0, 0, 6, 0, 0);
        for (int i = 0; i < 200; i++) rand_cycle(1);

        @(negedge clk); #1;
        idle_all();
        repeat (2) @(negedge clk);
        #5;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_register_file_sb
